// File: rtl/ensemble_pkg.sv
// Shared constants and types for the N-way classifier ensemble voter.
package ensemble_pkg;
    localparam int MAX_CLF     = 8;
    localparam int AGREE_LSB   = 16;
    localparam int AGREE_WIDTH = 8;
    localparam int CLASS_W     = 8;
    localparam int CNT_W       = $clog2(MAX_CLF + 1);

    typedef logic [CLASS_W-1:0] class_t;
    typedef logic [CNT_W-1:0]   cnt_t;
endpackage

// File: rtl/ens_result_fifo.sv
// Per-core class-result FIFO; full is derived from the registered count, so a pop
// in the same cycle does not open the push slot until the next cycle.
module ens_result_fifo
    import ensemble_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [W-1:0]           din_i,
    input  logic                   pop_i,
    output logic [W-1:0]           dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/ensemble_vote_n.sv
// Broadcasts one feature stream to NUM_CLF classifier cores, queues each core's
// per-sample class and emits a registered majority vote with its agreement count.
module ensemble_vote_n
    import ensemble_pkg::*;
#(
    parameter int NUM_CLF     = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = 4,
    parameter int CLASS_WIDTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [NUM_CLF*DATA_WIDTH-1:0] clf_in_tdata,
    output logic [NUM_CLF*KEEP_WIDTH-1:0] clf_in_tkeep,
    output logic [NUM_CLF-1:0]            clf_in_tvalid,
    input  logic [NUM_CLF-1:0]            clf_in_tready,
    output logic [NUM_CLF-1:0]            clf_in_tlast,
    input  logic [NUM_CLF*DATA_WIDTH-1:0] clf_out_tdata,
    input  logic [NUM_CLF-1:0]            clf_out_tvalid,
    output logic [NUM_CLF-1:0]            clf_out_tready,
    input  logic [NUM_CLF-1:0]            clf_out_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [31:0]                   vote_count,
    output logic [31:0]                   disagree_count
);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_CLF-1:0]                  acc_q, acc_d, in_hs, out_hs, full, empty;
    logic [NUM_CLF-1:0][DATA_WIDTH-1:0]  res_data;
    logic [NUM_CLF-1:0][CLASS_WIDTH-1:0] head;
    logic [NUM_CLF-1:0][FW-1:0]          fill;
    logic                                s_hs, fire, unused_ok;
    cnt_t                                cnt [NUM_CLF];
    cnt_t                                best;
    logic [CLASS_WIDTH-1:0]              win;
    logic [DATA_WIDTH-1:0]               vote_data;
    logic [DATA_WIDTH-1:0]               tdata_q;
    logic [KEEP_WIDTH-1:0]               tkeep_q;
    logic                                tvalid_q, tlast_q;
    logic [31:0]                         vote_q, dis_q;

    // acc_q remembers which cores already took the current beat so none sees it twice
    assign clf_in_tdata  = {NUM_CLF{s_axis_tdata}};
    assign clf_in_tkeep  = {NUM_CLF{s_axis_tkeep}};
    assign clf_in_tlast  = {NUM_CLF{s_axis_tlast}};
    assign clf_in_tvalid = rst ? '0 : ({NUM_CLF{s_axis_tvalid}} & ~acc_q);
    assign s_axis_tready = ~rst & (&(acc_q | clf_in_tready));
    assign s_hs          = s_axis_tvalid & s_axis_tready;
    assign in_hs         = clf_in_tvalid & clf_in_tready;
    assign acc_d         = s_hs ? '0 : (acc_q | in_hs);

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign clf_out_tready = rst ? '0 : ~full;
    assign out_hs         = clf_out_tvalid & clf_out_tready;
    assign res_data       = clf_out_tdata;

    for (genvar g = 0; g < NUM_CLF; g++) begin : g_fifo
        ens_result_fifo #(.W(CLASS_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (out_hs[g]),
            .din_i   (res_data[g][CLASS_WIDTH-1:0]),
            .pop_i   (fire),
            .dout_o  (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g]),
            .count_o (fill[g])
        );
    end

    assign unused_ok = ^{clf_out_tlast, fill, clf_out_tdata};
    assign fire      = ~(|empty) & (~tvalid_q | m_axis_tready);

    // strict '>' keeps the lowest core index among equally popular classes
    always_comb begin
        for (int i = 0; i < NUM_CLF; i++) begin
            cnt[i] = '0;
            for (int j = 0; j < NUM_CLF; j++)
                if (head[i] == head[j]) cnt[i] = cnt[i] + cnt_t'(1);
        end
        best = cnt[0];
        win  = head[0];
        for (int i = 1; i < NUM_CLF; i++) begin
            if (cnt[i] > best) begin
                best = cnt[i];
                win  = head[i];
            end
        end
        vote_data = '0;
        vote_data[CLASS_WIDTH-1:0] = win;
        vote_data[AGREE_LSB +: AGREE_WIDTH] = AGREE_WIDTH'(best);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            vote_q   <= '0;
            dis_q    <= '0;
        end else if (fire) begin
            tvalid_q <= 1'b1;
            tdata_q  <= vote_data;
            tkeep_q  <= '1;
            tlast_q  <= 1'b1;
            vote_q   <= vote_q + 32'd1;
            if (best != cnt_t'(NUM_CLF)) dis_q <= dis_q + 32'd1;
        end else if (m_axis_tready) begin
            tvalid_q <= 1'b0;
        end
    end

    assign m_axis_tdata   = tdata_q;
    assign m_axis_tkeep   = tkeep_q;
    assign m_axis_tvalid  = tvalid_q;
    assign m_axis_tlast   = tlast_q;
    assign vote_count     = vote_q;
    assign disagree_count = dis_q;
endmodule

// File: tb/tb_ensemble_vote_n.sv
// Randomized and directed bench for ensemble_vote_n against a histogram-based vote model.
module tb_ensemble_vote_n;
    import ensemble_pkg::*;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int CW = 8;
    localparam int FD = 4;

    logic            clk, rst;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic            s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [N*DW-1:0] clf_in_tdata;
    logic [N*KW-1:0] clf_in_tkeep;
    logic [N-1:0]    clf_in_tvalid, clf_in_tready, clf_in_tlast;
    logic [N*DW-1:0] clf_out_tdata;
    logic [N-1:0]    clf_out_tvalid, clf_out_tready, clf_out_tlast;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [31:0]     vote_count, disagree_count;

    ensemble_vote_n #(.NUM_CLF(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CLASS_WIDTH(CW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .clf_in_tdata(clf_in_tdata), .clf_in_tkeep(clf_in_tkeep), .clf_in_tvalid(clf_in_tvalid),
        .clf_in_tready(clf_in_tready), .clf_in_tlast(clf_in_tlast),
        .clf_out_tdata(clf_out_tdata), .clf_out_tvalid(clf_out_tvalid), .clf_out_tready(clf_out_tready),
        .clf_out_tlast(clf_out_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .vote_count(vote_count), .disagree_count(disagree_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int n_chk, n_bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [32:0] in_q [$];
    logic [31:0] sent_ref [$];
    logic [31:0] exp_q [$];
    logic [31:0] got_mem [N][512];
    int          got_n [N];
    class_t      res_mem [N][512];
    int          res_wr [N], res_rd [N];
    bit          res_pend [N], res_hold [N];
    int          in_stall [N];
    bit          s_pend, rnd, stall_chk, lat_chk;
    int          m_stall, tick_n, last_res_tick, hs0, out_n, mv_cnt, md_cnt;
    bit          prev_v, prev_r;
    logic [31:0] prev_d;

    // majority from a class histogram: best count, then the earliest core holding it
    function automatic logic [31:0] ref_vote(input int c0, input int c1, input int c2);
        int cls [N];
        int h [256];
        int best, win;
        cls = '{c0, c1, c2};
        foreach (h[k]) h[k] = 0;
        for (int i = 0; i < N; i++) h[cls[i]]++;
        best = 0;
        win  = 0;
        for (int i = 0; i < N; i++) if (h[cls[i]] > best) best = h[cls[i]];
        for (int i = N - 1; i >= 0; i--) if (h[cls[i]] == best) win = cls[i];
        return {8'd0, 8'(best), 8'd0, 8'(win)};
    endfunction

    task automatic add_sample(input int c0, input int c1, input int c2);
        logic [31:0] e;
        res_mem[0][res_wr[0]] = class_t'(c0); res_wr[0]++;
        res_mem[1][res_wr[1]] = class_t'(c1); res_wr[1]++;
        res_mem[2][res_wr[2]] = class_t'(c2); res_wr[2]++;
        e = ref_vote(c0, c1, c2);
        exp_q.push_back(e);
        mv_cnt++;
        if (e[23:16] != 8'(N)) md_cnt++;
    endtask

    task automatic send_beats(input int n);
        logic [31:0] d;
        for (int k = 0; k < n; k++) begin
            d = $urandom;
            in_q.push_back({(k == n - 1), d});
            sent_ref.push_back(d);
        end
    endtask

    task automatic drive();
        logic [31:0] r32;
        if (rst) begin
            s_axis_tvalid  = 1'b0;
            clf_out_tvalid = '0;
            clf_in_tready  = '0;
            return;
        end
        if (!s_pend && in_q.size() > 0 && (!rnd || $urandom_range(3) != 0)) s_pend = 1;
        s_axis_tvalid = s_pend;
        s_axis_tkeep  = '1;
        if (s_pend) {s_axis_tlast, s_axis_tdata} = in_q[0];
        for (int i = 0; i < N; i++) begin
            if (in_stall[i] > 0) begin
                clf_in_tready[i] = 1'b0;
                in_stall[i]--;
            end else begin
                clf_in_tready[i] = rnd ? ($urandom_range(2) != 0) : 1'b1;
            end
            if (!res_pend[i] && res_rd[i] < res_wr[i] && !res_hold[i] && (!rnd || $urandom_range(3) != 0)) begin
                res_pend[i] = 1;
                r32 = $urandom;
                clf_out_tdata[i*DW +: DW] = {r32[DW-1:CW], res_mem[i][res_rd[i]]};
                clf_out_tlast[i] = r32[0];
            end
            clf_out_tvalid[i] = res_pend[i];
        end
        if (m_stall > 0) begin
            m_axis_tready = 1'b0;
            m_stall--;
        end else begin
            m_axis_tready = rnd ? ($urandom_range(1) == 1) : 1'b1;
        end
    endtask

    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        tick_n++;
        if (!rst) begin
            for (int i = 0; i < N; i++)
                if (clf_in_tvalid[i] && clf_in_tready[i]) begin
                    got_mem[i][got_n[i]] = clf_in_tdata[i*DW +: DW];
                    got_n[i]++;
                end
            if (stall_chk && s_axis_tvalid && !clf_in_tready[1]) chk("src_stall_rdy", s_axis_tready, 0);
            if (s_axis_tvalid && s_axis_tready) begin
                void'(in_q.pop_front());
                s_pend = 0;
            end
            for (int i = 0; i < N; i++)
                if (clf_out_tvalid[i] && clf_out_tready[i]) begin
                    res_rd[i]++;
                    res_pend[i] = 0;
                    last_res_tick = tick_n;
                    if (i == 0) hs0++;
                end
            if (prev_v && !prev_r) begin
                chk("hold_valid", m_axis_tvalid, 1);
                chk("hold_data", m_axis_tdata, prev_d);
            end
            if (m_axis_tvalid) begin
                if (lat_chk) begin
                    chk("latency", tick_n - last_res_tick, 2);
                    lat_chk = 0;
                end
                if (m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_vote", m_axis_tvalid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("vote_data", m_axis_tdata, e);
                        chk("vote_keep_last", {m_axis_tkeep, m_axis_tlast}, 5'b11111);
                        out_n++;
                    end
                end
            end
            prev_v = m_axis_tvalid;
            prev_r = m_axis_tready;
            prev_d = m_axis_tdata;
        end else begin
            prev_v = 0;
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    function automatic bit busy();
        bit b;
        b = (in_q.size() > 0) || (exp_q.size() > 0) || m_axis_tvalid || (m_stall > 0);
        for (int i = 0; i < N; i++) if (res_rd[i] < res_wr[i]) b = 1;
        return b;
    endfunction

    task automatic drain(input int max);
        int t;
        t = 0;
        while (busy() && t < max) begin
            tick();
            t++;
        end
        if (busy()) chk("drain_timeout", t, 0);
    endtask

    task automatic chk_counts();
        chk("vote_count", vote_count, mv_cnt);
        chk("disagree_count", disagree_count, md_cnt);
    endtask

    task automatic chk_stream();
        for (int i = 0; i < N; i++) begin
            chk("bcast_beats", got_n[i], sent_ref.size());
            for (int k = 0; k < got_n[i] && k < sent_ref.size(); k++)
                chk("bcast_data", got_mem[i][k], sent_ref[k]);
            got_n[i] = 0;
        end
        sent_ref.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_q.delete();
        exp_q.delete();
        sent_ref.delete();
        s_pend = 0;
        m_stall = 0;
        mv_cnt = 0;
        md_cnt = 0;
        for (int i = 0; i < N; i++) begin
            res_wr[i] = 0; res_rd[i] = 0; got_n[i] = 0;
            res_pend[i] = 0; res_hold[i] = 0; in_stall[i] = 0;
        end
        drive();
        tick();
        tick();
        chk("rst_m_valid", m_axis_tvalid, 0);
        chk("rst_m_data", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, 0);
        chk("rst_in_valid", clf_in_tvalid, 0);
        chk("rst_s_ready", s_axis_tready, 0);
        chk("rst_out_ready", clf_out_tready, 0);
        chk("rst_counts", {vote_count, disagree_count}, 0);
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_bad = 0; tick_n = 0; out_n = 0; hs0 = 0; last_res_tick = 0;
        rnd = 0; stall_chk = 0; lat_chk = 0; prev_v = 0; prev_r = 0; prev_d = '0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 0; s_axis_tlast = 0;
        clf_in_tready = '0; clf_out_tdata = '0; clf_out_tvalid = '0; clf_out_tlast = '0;
        m_axis_tready = 0;
        do_reset();

        // directed votes, each checked for one-cycle head-to-valid latency
        lat_chk = 1; add_sample(5, 5, 2); drain(50); chk_counts();
        lat_chk = 1; add_sample(1, 2, 3); drain(50); chk_counts();
        lat_chk = 1; add_sample(4, 4, 4); drain(50); chk_counts();

        // core 1 stalls a 4-beat sample
        stall_chk = 1;
        in_stall[1] = 5;
        send_beats(4);
        drain(100);
        stall_chk = 0;
        chk_stream();

        // core 2 withholds results; the other FIFOs fill and back-pressure
        res_hold[2] = 1;
        hs0 = 0;
        for (int k = 0; k < 10; k++)
            add_sample($urandom_range(3), $urandom_range(3), $urandom_range(3));
        repeat (20) tick();
        chk("fifo_full_rdy0", clf_out_tready[0], 0);
        chk("fifo_full_rdy1", clf_out_tready[1], 0);
        chk("fifo_depth", hs0, FD);
        res_hold[2] = 0;
        drain(200);
        chk_counts();

        // output stalled 8 cycles, then drains one vote per cycle
        m_stall = 8;
        for (int k = 0; k < 5; k++)
            add_sample($urandom_range(2), $urandom_range(2), $urandom_range(2));
        repeat (9) tick();
        out_n = 0;
        repeat (3) tick();
        chk("drain_rate", out_n, 3);
        drain(100);
        chk_counts();

        // randomized traffic on every interface
        rnd = 1;
        for (int k = 0; k < 40; k++) begin
            add_sample($urandom_range(3), $urandom_range(3), $urandom_range(3));
            if (k % 8 == 0) send_beats($urandom_range(4, 1));
        end
        drain(3000);
        rnd = 0;
        drain(200);
        chk_stream();
        chk_counts();

        // reset with a half-accepted beat and partially filled FIFOs
        res_hold[2] = 1;
        for (int k = 0; k < 3; k++) add_sample(k, k + 1, k);
        in_stall[1] = 10;
        send_beats(3);
        repeat (5) tick();
        do_reset();
        add_sample(7, 7, 7);
        send_beats(2);
        drain(100);
        chk_stream();
        chk_counts();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
